apb_regfile: RTL and testbench

Parametrised APB4 completer with wait-state insertion, byte strobes and error response, fronting a bank of NUM_REGS software-visible 32-bit-aligned registers. It is the next generation of the project's APB slave: it adds PREADY/PSLVERR/PSTRB and configurable depth and latency. It sits behind the AHB-to-APB bridge and exports its register contents to peripheral logic.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slave_fsm.sv | 96 +++++++++
 rtl/apb_regfile.sv | 92 +++++++++
 tb/tb_apb_regfile.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB register-file completer.
//   apb_state_t : setup/access FSM state encoding
//   apb_req_t   : latched write payload (direction, data, byte strobes)
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB4 setup/access sequencer with wait-state counter, request latch and
// register-index decode.
//   clk, rst_n        : clock, async active-low reset
//   paddr..pstrb      : APB request inputs
//   req               : latched direction/data/strobes (registered)
//   ready_c           : access phase with wait count exhausted
//   err_c             : latched address is misaligned or outside the bank
//   commit_c          : write completes this cycle without error
//   idx_c             : register index decoded from the latched address
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_CYCLES = 0,
    localparam int unsigned      IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_STRB_W-1:0] pstrb,
    output apb_req_t              req,
    output logic                  ready_c,
    output logic                  err_c,
    output logic                  commit_c,
    output logic [IDX_W-1:0]      idx_c
);

    localparam int unsigned CNT_W = 4;

    apb_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] offset;

    // State, wait counter and request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            req   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load) begin
                addr <= paddr;
                req  <= '{write: pwrite, wdata: pwdata, strb: pstrb};
            end
        end
    end

    // Next state; leaving ACCESS with PSEL low is an abort with no side effect
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready depends only on internal state so PREADY never follows bus inputs
    assign ready_c  = (state == ACCESS) && (cnt == '0);
    assign commit_c = ready_c && psel && req.write && !err_c;

    // Word-aligned decode relative to BASE_ADDR
    assign offset = addr - BASE_ADDR;
    assign err_c  = (addr < BASE_ADDR) || (addr[1:0] != 2'b00) ||
                    ((offset >> 2) >= ADDR_W'(NUM_REGS));
    assign idx_c  = IDX_W'(offset >> 2);

endmodule

// File: rtl/apb_regfile.sv
// APB4 completer fronting NUM_REGS 32-bit registers with byte strobes,
// configurable wait states and error response.
//   PCLK, PRESETn              : clock, async active-low reset
//   PADDR..PSTRB               : APB request
//   PRDATA, PREADY, PSLVERR    : APB response (from internal state only)
//   regs_o                     : flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse_o                 : one-cycle pulse per register after a committed write
module apb_regfile
    import apb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = APB_DATA_W,
    parameter int unsigned       NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_CYCLES = 0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;

    apb_req_t          req;
    logic              ready;
    logic              err;
    logic              commit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] regs [NUM_REGS];

    apb_slave_fsm #(
        .ADDR_W      (ADDR_W),
        .NUM_REGS    (NUM_REGS),
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .paddr    (PADDR),
        .psel     (PSEL),
        .penable  (PENABLE),
        .pwrite   (PWRITE),
        .pwdata   (PWDATA),
        .pstrb    (PSTRB),
        .req      (req),
        .ready_c  (ready),
        .err_c    (err),
        .commit_c (commit),
        .idx_c    (idx)
    );

    // Register bank with byte-lane merge; a zero strobe still pulses
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit) begin
                wr_pulse_o[idx] <= 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (req.strb[b]) begin
                        regs[idx][b*8 +: 8] <= req.wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Response; read data is forced to zero outside an error-free read completion
    assign PREADY  = ready;
    assign PSLVERR = ready && err;
    assign PRDATA  = (ready && !err && !req.write) ? regs[idx] : '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: tb/tb_apb_regfile.sv
// Directed bench for apb_regfile: three instances at 0, 3 and 2 wait states
// sharing one bus, each with its own PSEL.
module tb_apb_regfile;
    import apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        penable;
    logic        pwrite;
    logic [2:0]  psel;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata   [3];
    logic [511:0] regs_q  [3];
    logic [15:0] wr_pulse [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 PCLK = ~PCLK;

    apb_regfile #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[0]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .regs_o(regs_q[0]), .wr_pulse_o(wr_pulse[0])
    );

    apb_regfile #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[1]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .regs_o(regs_q[1]), .wr_pulse_o(wr_pulse[1])
    );

    apb_regfile #(.WAIT_CYCLES(2)) u_w2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[2]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
        .regs_o(regs_q[2]), .wr_pulse_o(wr_pulse[2])
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transfer; returns in the cycle after completion
    task automatic xfer(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int exp_wait, input string tag,
                        output logic [31:0] rd, output logic err);
        int n = 0;
        psel[u] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        tick();
        penable = 1'b1;
        while (pready[u] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " waits"}, 512'(n), 512'(exp_wait));
        rd  = prdata[u];
        err = pslverr[u];
        tick();
        psel[u] = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0]  rd;
    logic         er;
    logic [511:0] m;

    initial begin
        PRESETn = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        m       = '0;
        tick();
        tick();
        check("rst pready", 512'(pready), 512'(0));
        check("rst pslverr", 512'(pslverr), 512'(0));
        check("rst prdata", 512'(prdata[0]), 512'(0));
        check("rst regs", regs_q[0], 512'(0));
        check("rst pulse", 512'(wr_pulse[0]), 512'(0));
        PRESETn = 1'b1;
        tick();

        // Full-word write then read, zero wait states
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, "wr8", rd, er);
        m[95:64] = 32'hDEADBEEF;
        check("wr8 err", 512'(er), 512'(0));
        check("wr8 pulse", 512'(wr_pulse[0]), 512'(16'h0004));
        check("wr8 regs", regs_q[0], m);
        tick();
        check("wr8 pulse gone", 512'(wr_pulse[0]), 512'(0));
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, "rd8", rd, er);
        check("rd8 data", 512'(rd), 512'(32'hDEADBEEF));
        check("rd8 err", 512'(er), 512'(0));

        // Partial strobe merge, back-to-back transfers
        xfer(0, 1'b1, 32'h4, 32'h11223344, 4'hF, 0, "wr4a", rd, er);
        xfer(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 0, "wr4b", rd, er);
        m[63:32] = 32'h11BB33DD;
        check("wr4b pulse", 512'(wr_pulse[0]), 512'(16'h0002));
        check("wr4b regs", regs_q[0], m);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, "rd4", rd, er);
        check("rd4 data", 512'(rd), 512'(32'h11BB33DD));

        // Zero strobe: OKAY, pulse, no data change
        xfer(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 0, "wr4z", rd, er);
        check("wr4z err", 512'(er), 512'(0));
        check("wr4z pulse", 512'(wr_pulse[0]), 512'(16'h0002));
        check("wr4z regs", regs_q[0], m);

        // Error responses: out of range and misaligned
        xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, "wr40", rd, er);
        check("wr40 err", 512'(er), 512'(1));
        check("wr40 pulse", 512'(wr_pulse[0]), 512'(0));
        check("wr40 regs", regs_q[0], m);
        xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 0, "wr6", rd, er);
        check("wr6 err", 512'(er), 512'(1));
        check("wr6 pulse", 512'(wr_pulse[0]), 512'(0));
        check("wr6 regs", regs_q[0], m);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, "rd40", rd, er);
        check("rd40 err", 512'(er), 512'(1));
        check("rd40 data", 512'(rd), 512'(0));
        check("idle pslverr", 512'(pslverr[0]), 512'(0));

        // Three wait states
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3, "w3 rd0", rd, er);
        check("w3 rd0 data", 512'(rd), 512'(0));
        check("w3 rd0 err", 512'(er), 512'(0));
        xfer(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3, "w3 wr0", rd, er);
        check("w3 wr0 regs", 512'(regs_q[1][31:0]), 512'(32'hCAFEF00D));
        check("w3 wr0 pulse", 512'(wr_pulse[1]), 512'(16'h0001));

        // Reset during the wait state of a write
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h4;
        pwdata  = 32'h12345678;
        pstrb   = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        check("rst mid pready pre", 512'(pready[1]), 512'(0));
        PRESETn = 1'b0;
        #1;
        check("rst mid pready", 512'(pready[1]), 512'(0));
        check("rst mid regs", regs_q[1], 512'(0));
        tick();
        PRESETn = 1'b1;
        psel[1] = 1'b0;
        penable = 1'b0;
        tick();
        check("rst mid no commit", regs_q[1], 512'(0));
        check("rst mid pulse", 512'(wr_pulse[1]), 512'(0));
        xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 3, "post rst rd4", rd, er);
        check("post rst rd4 data", 512'(rd), 512'(0));
        xfer(1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, 3, "post rst wr8", rd, er);
        check("post rst wr8 regs", 512'(regs_q[1][95:64]), 512'(32'h0BADF00D));

        // Abort: PSEL dropped during ACCESS with two wait states
        psel[2] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'hC;
        pwdata  = 32'h5555AAAA;
        pstrb   = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        check("abort pready", 512'(pready[2]), 512'(0));
        psel[2] = 1'b0;
        penable = 1'b0;
        tick();
        check("abort idle", 512'(u_w2.u_fsm.state == IDLE), 512'(1));
        check("abort pulse", 512'(wr_pulse[2]), 512'(0));
        tick();
        check("abort regs", regs_q[2], 512'(0));
        xfer(2, 1'b0, 32'hC, 32'h0, 4'h0, 2, "abort rdC", rd, er);
        check("abort rdC data", 512'(rd), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
